segment_load_sequencer: RTL and testbench
=========================================

// Module: segment_load_sequencer
// PURPOSE
//  Sequences a MOV/POP-to-segment-register load. Takes the 3-bit sreg code and a 16-bit selector.
//  Real mode: forms base = selector<<4 directly. Protected mode: fetches the 8-byte descriptor
//  from GDT/LDT over a memory handshake, validates it and writes the hidden segment cache.
//  Sits between decode (sreg code, ES=0 CS=1 SS=2 DS=3 FS=4 GS=5) and the segment register file.
// PARAMETERS
//  ADDR_W   32  linear address width of descriptor fetch
// PORTS
//  clock          in   1   single clock
//  reset          in   1   asynchronous, active-high
//  load_valid     in   1   load request
//  load_ready     out  1   high only in IDLE
//  load_sreg      in   3   target segment register code
//  load_selector  in   16  selector value
//  protected_mode in   1   CR0.PE
//  gdtr_base      in   32  GDT base;  gdtr_limit in 16  GDT limit
//  ldtr_base      in   32  LDT base;  ldtr_limit in 16  LDT limit
//  mem_req        out  1   descriptor read request
//  mem_addr       out  ADDR_W  dword address of read
//  mem_ack        in   1   read complete; mem_rdata valid this cycle
//  mem_rdata      in   32  read data
//  sreg_we        out  1   one-cycle write strobe to segment register file
//  sreg_index     out  3   register written
//  sreg_selector  out  16; sreg_base out 32; sreg_limit out 20 (raw); sreg_attr out 12 ({hi[23:20],hi[15:8]})
//  done           out  1   one-cycle pulse, load finished OK
//  fault          out  1   one-cycle pulse, load aborted
//  fault_vector   out  8   6=#UD 11=#NP 12=#SS 13=#GP
//  fault_code     out  16  error code = {selector[15:2],2'b00}, or 0 for null-selector faults
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0 except load_ready=1.
//  - Reset mid-operation: abandons any outstanding mem_req with no sreg_we. The memory side must drop it.
//  - Accept on load_valid&&load_ready. Registers sreg, selector, mode and the chosen table base/limit.
//    Inputs are ignored afterwards.
//  - FSM: IDLE -> CHECK -> {WRITE | FAULT | READ_LO}; READ_LO -> READ_HI -> VALIDATE -> {WRITE | FAULT};
//    WRITE and FAULT -> IDLE.
//  - CHECK, sreg 6/7: FAULT #UD, code 0, no memory access.
//  - CHECK, real mode: base={12'h0,sel,4'h0}, limit=20'h0FFFF, attr=12'h093 (present, RW data).
//    sreg_we/done occur in the 2nd cycle after acceptance.
//  - CHECK, protected, null selector (sel[15:2]==0 with TI=0):
//    CS/SS: FAULT #GP code 0. Others: WRITE with attr=0 (not present), base=0, limit=0, no memory access.
//  - CHECK, table limit: table=TI?LDT:GDT. If {sel[15:3],3'b111} > limit (17-bit compare): FAULT #GP(sel).
//  - READ_LO: mem_req=1, mem_addr=base+{sel[15:3],3'b000}; hold both until mem_ack and capture lo.
//  - READ_HI: same handshake, addr+4; captures hi. mem_req may stay high across the two beats.
//    Wait for mem_ack is unbounded.
//  - VALIDATE, checked in this order:
//    S=hi[12]==0 -> #GP
//    CS: type hi[11]==0 -> #GP
//    SS: hi[11]==1 or hi[9]==0 -> #GP
//    others: hi[11]&~hi[9] (execute-only code) -> #GP
//    P=hi[15]==0 -> #SS for SS, else #NP. All with code = sel.
//  - DPL/RPL/CPL privilege checks are not done here; the privilege unit owns them.
//  - WRITE fields: base={hi[31:24],hi[7:0],lo[31:16]}, limit={hi[19:16],lo[15:0]}.
//    Limit scaling by G is done downstream.
//  - WRITE: sreg_we=1 and done=1 for exactly one cycle, data stable that cycle.
//    FAULT: fault=1 for exactly one cycle, never together with sreg_we.
//  - load_ready is 0 from acceptance until the cycle after WRITE/FAULT, so back-to-back loads lose one cycle.
// STRUCTURE
//  - segment_pkg: sreg_e enum (ES..GS), seq_state_e, vector constants (VEC_UD/NP/SS/GP),
//    descriptor field extraction functions (desc_base, desc_limit, desc_attr).
//  - Sub-module segment_descriptor_check: combinational; (sreg, hi dword) -> ok, vector.
//    Reused later by the task-switch unit.
// TESTING
//  - Real mode, DS sel=16'h1234: sreg_we 2 cycles after accept; base=32'h00012340, limit=20'h0FFFF;
//    mem_req never high.
//  - Protected mode, GDT base 32'h1000, sel=16'h0010 (SS): reads at 32'h1010 then 32'h1014.
//    Descriptor 32'h0000FFFF/32'h00CF9300 gives base=0, limit=20'hFFFFF, attr=12'hC93.
//  - Protected mode, SS sel=16'h0003: fault #GP code 0. ES same selector: write with attr=0, no mem_req.
//  - GDT limit 16'h0017, sel=16'h0018: #GP code 16'h0018, no mem_req.
//  - Descriptor with P=0: DS gives #NP code=sel; SS gives #SS. CS with data-type descriptor gives #GP.
//  - Assert reset while waiting for mem_ack in READ_HI: mem_req low at once, no sreg_we.
//    After release load_ready=1 and the next load completes normally. sreg 7 gives #UD.

Source files
------------

// File: rtl/segment_pkg.sv
// Shared types, fault vectors and descriptor field helpers for segment register loading.
package segment_pkg;

  typedef enum logic [2:0] {
    SREG_ES = 3'd0,
    SREG_CS = 3'd1,
    SREG_SS = 3'd2,
    SREG_DS = 3'd3,
    SREG_FS = 3'd4,
    SREG_GS = 3'd5
  } sreg_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ_LO,
    ST_READ_HI,
    ST_VALIDATE,
    ST_WRITE,
    ST_FAULT
  } seq_state_e;

  localparam logic [7:0] VEC_UD = 8'd6;
  localparam logic [7:0] VEC_NP = 8'd11;
  localparam logic [7:0] VEC_SS = 8'd12;
  localparam logic [7:0] VEC_GP = 8'd13;

  // Real-mode segments are always 64 KiB, present, read/write data.
  localparam logic [19:0] REAL_LIMIT = 20'h0FFFF;
  localparam logic [11:0] REAL_ATTR  = 12'h093;

  function automatic logic [31:0] desc_base(input logic [31:0] lo, input logic [31:0] hi);
    return {hi[31:24], hi[7:0], lo[31:16]};
  endfunction

  // Raw 20-bit limit; granularity scaling happens downstream.
  function automatic logic [19:0] desc_limit(input logic [31:0] lo, input logic [31:0] hi);
    return {hi[19:16], lo[15:0]};
  endfunction

  function automatic logic [11:0] desc_attr(input logic [31:0] hi);
    return {hi[23:20], hi[15:8]};
  endfunction

endpackage

// File: rtl/segment_descriptor_check.sv
// Combinational type/presence validation of a segment descriptor's high dword
// for a given target segment register. Privilege checks live elsewhere.
module segment_descriptor_check
  import segment_pkg::*;
(
  input  logic [2:0]  sreg,
  input  logic [31:0] hi,
  output logic        ok,
  output logic [7:0]  vector
);

  logic unused_hi;
  assign unused_hi = ^{hi[31:16], hi[14:13], hi[10], hi[8:0]};

  // Checks are prioritised: descriptor class, then type vs. register, then presence.
  always_comb begin
    ok     = 1'b1;
    vector = 8'd0;
    if (!hi[12]) begin
      ok     = 1'b0;
      vector = VEC_GP;
    end else if (sreg == SREG_CS && !hi[11]) begin
      ok     = 1'b0;
      vector = VEC_GP;
    end else if (sreg == SREG_SS && (hi[11] || !hi[9])) begin
      ok     = 1'b0;
      vector = VEC_GP;
    end else if (sreg != SREG_CS && sreg != SREG_SS && hi[11] && !hi[9]) begin
      ok     = 1'b0;
      vector = VEC_GP;
    end else if (!hi[15]) begin
      ok     = 1'b0;
      vector = (sreg == SREG_SS) ? VEC_SS : VEC_NP;
    end
  end

endmodule

// File: rtl/segment_load_sequencer.sv
// Sequences a load of a segment register: direct base formation in real mode,
// descriptor fetch and validation in protected mode, then a one-cycle write
// strobe to the segment register file or a one-cycle fault pulse.
module segment_load_sequencer
  import segment_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [2:0]        load_sreg,
  input  logic [15:0]       load_selector,
  input  logic              protected_mode,
  input  logic [31:0]       gdtr_base,
  input  logic [15:0]       gdtr_limit,
  input  logic [31:0]       ldtr_base,
  input  logic [15:0]       ldtr_limit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              sreg_we,
  output logic [2:0]        sreg_index,
  output logic [15:0]       sreg_selector,
  output logic [31:0]       sreg_base,
  output logic [19:0]       sreg_limit,
  output logic [11:0]       sreg_attr,
  output logic              done,
  output logic              fault,
  output logic [7:0]        fault_vector,
  output logic [15:0]       fault_code
);

  seq_state_e  state_q, state_d;

  logic [2:0]  sreg_q;
  logic [15:0] sel_q;
  logic        pm_q;
  logic [31:0] tbl_base_q;
  logic [15:0] tbl_limit_q;
  logic [31:0] lo_q, hi_q;
  logic [31:0] res_base_q;
  logic [19:0] res_limit_q;
  logic [11:0] res_attr_q;
  logic [7:0]  vec_q;
  logic [15:0] code_q;

  logic        accept;
  logic        bad_sreg;
  logic        null_sel;
  logic        stack_or_code;
  logic        over_limit;
  logic [31:0] desc_addr;
  logic [31:0] beat_addr;
  logic        chk_ok;
  logic [7:0]  chk_vec;

  assign accept        = load_valid && (state_q == ST_IDLE);
  assign bad_sreg      = sreg_q[2] && sreg_q[1];
  assign null_sel      = (sel_q[15:2] == 14'd0);
  assign stack_or_code = (sreg_q == SREG_CS) || (sreg_q == SREG_SS);
  assign over_limit    = {1'b0, sel_q[15:3], 3'b111} > {1'b0, tbl_limit_q};
  assign desc_addr     = tbl_base_q + {16'h0, sel_q[15:3], 3'b000};
  assign beat_addr     = (state_q == ST_READ_HI) ? desc_addr + 32'd4 : desc_addr;

  segment_descriptor_check u_check (
    .sreg   (sreg_q),
    .hi     (hi_q),
    .ok     (chk_ok),
    .vector (chk_vec)
  );

  // State register; reset abandons any in-flight descriptor fetch immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bad_sreg)                  state_d = ST_FAULT;
        else if (!pm_q)                state_d = ST_WRITE;
        else if (null_sel)             state_d = stack_or_code ? ST_FAULT : ST_WRITE;
        else if (over_limit)           state_d = ST_FAULT;
        else                           state_d = ST_READ_LO;
      end
      ST_READ_LO: begin
        if (mem_ack) state_d = ST_READ_HI;
      end
      ST_READ_HI: begin
        if (mem_ack) state_d = ST_VALIDATE;
      end
      ST_VALIDATE: begin
        state_d = chk_ok ? ST_WRITE : ST_FAULT;
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture, descriptor beats and result formation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg_q      <= 3'd0;
      sel_q       <= 16'd0;
      pm_q        <= 1'b0;
      tbl_base_q  <= 32'd0;
      tbl_limit_q <= 16'd0;
      lo_q        <= 32'd0;
      hi_q        <= 32'd0;
      res_base_q  <= 32'd0;
      res_limit_q <= 20'd0;
      res_attr_q  <= 12'd0;
      vec_q       <= 8'd0;
      code_q      <= 16'd0;
    end else begin
      if (accept) begin
        sreg_q      <= load_sreg;
        sel_q       <= load_selector;
        pm_q        <= protected_mode;
        tbl_base_q  <= load_selector[2] ? ldtr_base  : gdtr_base;
        tbl_limit_q <= load_selector[2] ? ldtr_limit : gdtr_limit;
      end
      if (state_q == ST_CHECK) begin
        if (pm_q) begin
          // Null selector loaded into a data register: not-present empty segment.
          res_base_q  <= 32'd0;
          res_limit_q <= 20'd0;
          res_attr_q  <= 12'd0;
        end else begin
          res_base_q  <= {12'h0, sel_q, 4'h0};
          res_limit_q <= REAL_LIMIT;
          res_attr_q  <= REAL_ATTR;
        end
        vec_q  <= bad_sreg ? VEC_UD : VEC_GP;
        code_q <= (bad_sreg || null_sel) ? 16'd0 : {sel_q[15:2], 2'b00};
      end
      if (state_q == ST_READ_LO && mem_ack) lo_q <= mem_rdata;
      if (state_q == ST_READ_HI && mem_ack) hi_q <= mem_rdata;
      if (state_q == ST_VALIDATE) begin
        res_base_q  <= desc_base(lo_q, hi_q);
        res_limit_q <= desc_limit(lo_q, hi_q);
        res_attr_q  <= desc_attr(hi_q);
        vec_q       <= chk_vec;
        code_q      <= {sel_q[15:2], 2'b00};
      end
    end
  end

  assign load_ready    = (state_q == ST_IDLE);
  assign mem_req       = (state_q == ST_READ_LO) || (state_q == ST_READ_HI);
  assign mem_addr      = mem_req ? ADDR_W'(beat_addr) : '0;

  assign sreg_we       = (state_q == ST_WRITE);
  assign done          = sreg_we;
  assign sreg_index    = sreg_we ? sreg_q      : 3'd0;
  assign sreg_selector = sreg_we ? sel_q       : 16'd0;
  assign sreg_base     = sreg_we ? res_base_q  : 32'd0;
  assign sreg_limit    = sreg_we ? res_limit_q : 20'd0;
  assign sreg_attr     = sreg_we ? res_attr_q  : 12'd0;

  assign fault         = (state_q == ST_FAULT);
  assign fault_vector  = fault ? vec_q  : 8'd0;
  assign fault_code    = fault ? code_q : 16'd0;

endmodule

// File: tb/tb_segment_load_sequencer.sv
// Scoreboard bench for segment_load_sequencer with a simple descriptor memory responder.
module tb_segment_load_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [2:0]  load_sreg = 3'd0;
  logic [15:0] load_selector = 16'd0;
  logic        protected_mode = 1'b0;
  logic [31:0] gdtr_base = 32'd0;
  logic [15:0] gdtr_limit = 16'd0;
  logic [31:0] ldtr_base = 32'd0;
  logic [15:0] ldtr_limit = 16'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        sreg_we;
  logic [2:0]  sreg_index;
  logic [15:0] sreg_selector;
  logic [31:0] sreg_base;
  logic [19:0] sreg_limit;
  logic [11:0] sreg_attr;
  logic        done;
  logic        fault;
  logic [7:0]  fault_vector;
  logic [15:0] fault_code;

  typedef struct {
    bit          flt;
    logic [2:0]  idx;
    logic [15:0] sel;
    logic [31:0] base;
    logic [19:0] lim;
    logic [11:0] attr;
    logic [7:0]  vec;
    logic [15:0] code;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] addr_log[$];
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          checks = 0;
  int          failures = 0;

  segment_load_sequencer #(.ADDR_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_sreg      (load_sreg),
    .load_selector  (load_selector),
    .protected_mode (protected_mode),
    .gdtr_base      (gdtr_base),
    .gdtr_limit     (gdtr_limit),
    .ldtr_base      (ldtr_base),
    .ldtr_limit     (ldtr_limit),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .sreg_we        (sreg_we),
    .sreg_index     (sreg_index),
    .sreg_selector  (sreg_selector),
    .sreg_base      (sreg_base),
    .sreg_limit     (sreg_limit),
    .sreg_attr      (sreg_attr),
    .done           (done),
    .fault          (fault),
    .fault_vector   (fault_vector),
    .fault_code     (fault_code)
  );

  always #5 clock = ~clock;

  // Memory responder: one-cycle ack per beat, stalls forever on stall_addr.
  always @(negedge clock) begin
    if (mem_ack) begin
      mem_ack <= 1'b0;
    end else if (mem_req && mem_addr != stall_addr) begin
      mem_ack   <= 1'b1;
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
      addr_log.push_back(mem_addr);
    end
  end

  task automatic expect_write(input logic [2:0] idx, input logic [15:0] sel, input logic [31:0] base,
                              input logic [19:0] lim, input logic [11:0] attr);
    exp_t e;
    e.flt = 1'b0; e.idx = idx; e.sel = sel; e.base = base; e.lim = lim; e.attr = attr;
    e.vec = 8'd0; e.code = 16'd0;
    sb.push_back(e);
  endtask

  task automatic expect_fault(input logic [7:0] vec, input logic [15:0] code);
    exp_t e;
    e.flt = 1'b1; e.idx = 3'd0; e.sel = 16'd0; e.base = 32'd0; e.lim = 20'd0; e.attr = 12'd0;
    e.vec = vec; e.code = code;
    sb.push_back(e);
  endtask

  task automatic set_desc(input logic [31:0] addr, input logic [31:0] lo, input logic [31:0] hi);
    mem[addr]         = lo;
    mem[addr + 32'd4] = hi;
  endtask

  // Presents one request, holds it for the accepting edge, then scrambles the inputs.
  task automatic start_load(input logic [2:0] s, input logic [15:0] sel, input logic pm);
    load_sreg = s; load_selector = sel; protected_mode = pm; load_valid = 1'b1;
    @(posedge clock); #1;
    load_valid = 1'b0;
    load_sreg = 3'($urandom); load_selector = 16'($urandom); protected_mode = 1'($urandom);
  endtask

  // Waits for the next result, pops the scoreboard and compares, then checks the pulse ended.
  task automatic drain(input string name, output int lat);
    int n = 0;
    exp_t e;
    while (!(sreg_we || fault) && n < 60) begin
      @(posedge clock); #1; n++;
    end
    lat = n + 1;
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL %s timeout: no sreg_we/fault within 60 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected output: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if ({sreg_we, done, fault} !== (e.flt ? 3'b001 : 3'b110)) begin
      failures++;
      $display("FAIL %s flags we/done/fault got %b want %b", name, {sreg_we, done, fault},
               (e.flt ? 3'b001 : 3'b110));
    end
    if (e.flt) begin
      checks++;
      if (fault_vector !== e.vec || fault_code !== e.code) begin
        failures++;
        $display("FAIL %s fault got vec=%0d code=%h want vec=%0d code=%h", name,
                 fault_vector, fault_code, e.vec, e.code);
      end
    end else begin
      checks++;
      if (sreg_index !== e.idx || sreg_selector !== e.sel) begin
        failures++;
        $display("FAIL %s index/selector got %0d/%h want %0d/%h", name,
                 sreg_index, sreg_selector, e.idx, e.sel);
      end
      checks++;
      if (sreg_base !== e.base || sreg_limit !== e.lim || sreg_attr !== e.attr) begin
        failures++;
        $display("FAIL %s base/limit/attr got %h/%h/%h want %h/%h/%h", name,
                 sreg_base, sreg_limit, sreg_attr, e.base, e.lim, e.attr);
      end
    end
    @(posedge clock); #1;
    checks++;
    if ({sreg_we, done, fault, load_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL %s after-pulse we/done/fault/ready got %b want 0001", name,
               {sreg_we, done, fault, load_ready});
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({load_ready, mem_req, sreg_we, done, fault} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctrl ready/req/we/done/fault got %b want 10000",
               {load_ready, mem_req, sreg_we, done, fault});
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (load_ready !== 1'b1 || sreg_base !== 32'd0 || fault_vector !== 8'd0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL reset_release ready=%b base=%h vec=%h addr=%h want 1/0/0/0",
               load_ready, sreg_base, fault_vector, mem_addr);
    end
  endtask

  task automatic test_real_mode;
    int lat;
    int n0 = addr_log.size();
    expect_write(3'd3, 16'h1234, 32'h0001_2340, 20'h0FFFF, 12'h093);
    start_load(3'd3, 16'h1234, 1'b0);
    checks++;
    if (load_ready !== 1'b0) begin
      failures++;
      $display("FAIL real_busy load_ready got %b want 0", load_ready);
    end
    drain("real_ds", lat);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL real_latency got %0d want 2", lat);
    end
    expect_write(3'd1, 16'hFFFF, 32'h000F_FFF0, 20'h0FFFF, 12'h093);
    start_load(3'd1, 16'hFFFF, 1'b0);
    drain("real_cs", lat);
    checks++;
    if (addr_log.size() !== n0) begin
      failures++;
      $display("FAIL real_no_mem reads got %0d want 0", addr_log.size() - n0);
    end
  endtask

  task automatic test_protected;
    int lat;
    int n0;
    gdtr_base = 32'h0000_1000; gdtr_limit = 16'hFFFF;
    ldtr_base = 32'h0000_2000; ldtr_limit = 16'h00FF;
    set_desc(32'h1010, 32'h0000_FFFF, 32'h00CF_9300);
    set_desc(32'h2008, 32'h1234_5678, 32'hAB4F_92CD);
    n0 = addr_log.size();
    expect_write(3'd2, 16'h0010, 32'h0000_0000, 20'hFFFFF, 12'hC93);
    start_load(3'd2, 16'h0010, 1'b1);
    drain("pm_ss_gdt", lat);
    checks++;
    if (addr_log.size() !== n0 + 2 || addr_log[n0] !== 32'h1010 || addr_log[n0+1] !== 32'h1014) begin
      failures++;
      $display("FAIL pm_gdt_addrs got n=%0d %h %h want n=2 00001010 00001014",
               addr_log.size() - n0, addr_log[n0], addr_log[n0+1]);
    end
    n0 = addr_log.size();
    expect_write(3'd3, 16'h000C, 32'hABCD_1234, 20'hF5678, 12'h492);
    start_load(3'd3, 16'h000C, 1'b1);
    drain("pm_ds_ldt", lat);
    checks++;
    if (addr_log.size() !== n0 + 2 || addr_log[n0] !== 32'h2008 || addr_log[n0+1] !== 32'h200C) begin
      failures++;
      $display("FAIL pm_ldt_addrs got n=%0d %h %h want n=2 00002008 0000200c",
               addr_log.size() - n0, addr_log[n0], addr_log[n0+1]);
    end
  endtask

  task automatic test_null_and_limit;
    int lat;
    int n0 = addr_log.size();
    gdtr_base = 32'h0000_1000; gdtr_limit = 16'hFFFF;
    expect_fault(8'd13, 16'h0000);
    start_load(3'd2, 16'h0003, 1'b1);
    drain("null_ss", lat);
    expect_write(3'd0, 16'h0003, 32'd0, 20'd0, 12'h000);
    start_load(3'd0, 16'h0003, 1'b1);
    drain("null_es", lat);
    expect_fault(8'd13, 16'h0000);
    start_load(3'd1, 16'h0000, 1'b1);
    drain("null_cs", lat);
    gdtr_limit = 16'h0017;
    expect_fault(8'd13, 16'h0018);
    start_load(3'd3, 16'h0018, 1'b1);
    drain("limit_over", lat);
    checks++;
    if (addr_log.size() !== n0) begin
      failures++;
      $display("FAIL null_limit_no_mem reads got %0d want 0", addr_log.size() - n0);
    end
    expect_write(3'd3, 16'h0012, 32'h0000_0000, 20'hFFFFF, 12'hC93);
    start_load(3'd3, 16'h0012, 1'b1);
    drain("limit_edge", lat);
    gdtr_limit = 16'hFFFF;
  endtask

  task automatic test_validate;
    int lat;
    set_desc(32'h1018, 32'h0000_FFFF, 32'h00CF_1300);
    set_desc(32'h1020, 32'h0000_FFFF, 32'h00CF_8200);
    set_desc(32'h1028, 32'h0000_FFFF, 32'h00CF_9800);
    expect_fault(8'd11, 16'h0018);
    start_load(3'd3, 16'h001B, 1'b1);
    drain("np_ds", lat);
    expect_fault(8'd12, 16'h0018);
    start_load(3'd2, 16'h0018, 1'b1);
    drain("np_ss", lat);
    expect_fault(8'd13, 16'h0010);
    start_load(3'd1, 16'h0010, 1'b1);
    drain("cs_data", lat);
    expect_fault(8'd13, 16'h0020);
    start_load(3'd4, 16'h0020, 1'b1);
    drain("system_desc", lat);
    expect_fault(8'd13, 16'h0028);
    start_load(3'd5, 16'h0029, 1'b1);
    drain("exec_only_gs", lat);
    expect_write(3'd1, 16'h0028, 32'h0000_0000, 20'hFFFFF, 12'hC98);
    start_load(3'd1, 16'h0028, 1'b1);
    drain("cs_code", lat);
  endtask

  task automatic test_reset_mid_fetch;
    int n = 0;
    int lat;
    logic saw_we = 1'b0;
    stall_addr = 32'h0000_1014;
    start_load(3'd2, 16'h0010, 1'b1);
    while (!(mem_req && mem_addr == 32'h1014) && n < 20) begin
      @(posedge clock); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL midreset_reach_hi timeout: mem_req=%b addr=%h", mem_req, mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_async req/ready got %b/%b want 0/1", mem_req, load_ready);
    end
    repeat (3) begin
      @(posedge clock); #1;
      saw_we = saw_we | sreg_we | fault;
    end
    reset = 1'b0;
    stall_addr = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    saw_we = saw_we | sreg_we | fault;
    checks++;
    if (saw_we !== 1'b0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_quiet we_or_fault=%b ready=%b want 0/1", saw_we, load_ready);
    end
    expect_write(3'd2, 16'h0010, 32'h0000_0000, 20'hFFFFF, 12'hC93);
    start_load(3'd2, 16'h0010, 1'b1);
    drain("after_reset", lat);
    expect_fault(8'd6, 16'h0000);
    start_load(3'd7, 16'h0010, 1'b1);
    drain("sreg7_ud", lat);
    expect_fault(8'd6, 16'h0000);
    start_load(3'd6, 16'h1234, 1'b0);
    drain("sreg6_ud", lat);
  endtask

  initial begin
    test_reset();
    test_real_mode();
    test_protected();
    test_null_and_limit();
    test_validate();
    test_reset_mid_fetch();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
